// File: rtl/gcd_operand_sequencer.sv
// gcd_operand_sequencer: queues operand pairs in a 2-entry FIFO and sequences
// an external GCD controller/datapath (clear, load A, load B, wait for done).
// Zero operands bypass the core. Jobs that never finish are aborted after TIMEOUT
// wait cycles, and the core is reset.
module gcd_operand_sequencer #(
   parameter int WIDTH   = 16,
   parameter int TIMEOUT = 70000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             core_rst,
   output logic             start,
   output logic [WIDTH-1:0] data_in,
   input  logic             done,
   input  logic [WIDTH-1:0] gcd_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_err,
   output logic             busy
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TLIM = CW'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_LDA,
      S_LDB,
      S_WAIT,
      S_OUT
   } state_t;

   state_t state;

   logic [2*WIDTH-1:0] mem [2];
   logic               wr_ptr;
   logic               rd_ptr;
   logic [1:0]         count;
   logic               push;
   logic               pop;
   logic [WIDTH-1:0]   head_a;
   logic [WIDTH-1:0]   head_b;

   logic [WIDTH-1:0]   wa;
   logic [WIDTH-1:0]   wb;
   logic [CW-1:0]      cnt;
   logic [CW-1:0]      cnt_inc;
   logic               core_rst_q;

   assign in_ready = (count != 2'd2);
   assign push     = in_valid && in_ready;
   assign pop      = (state == S_IDLE) && (count != 2'd0);
   assign head_a   = mem[rd_ptr][2*WIDTH-1:WIDTH];
   assign head_b   = mem[rd_ptr][WIDTH-1:0];
   assign cnt_inc  = cnt + CW'(1);
   assign busy     = (state != S_IDLE) || (count != 2'd0);
   // The core is held in reset together with this block while rst is asserted.
   assign core_rst = core_rst_q || rst;

   // FIFO storage; contents are meaningless while count is zero, so no reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {in_a, in_b};
   end

   // FIFO pointers and occupancy; push and pop together leave count unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Job sequencer with registered core controls and result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         wa         <= '0;
         wb         <= '0;
         cnt        <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_err    <= 1'b0;
         start      <= 1'b0;
         data_in    <= '0;
         core_rst_q <= 1'b0;
      end else begin
         start      <= 1'b0;
         data_in    <= '0;
         core_rst_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pop) begin
                  wa <= head_a;
                  wb <= head_b;
                  if (head_a == '0 || head_b == '0) begin
                     // One zero operand yields the other; both zero yields 0 with error.
                     out_valid <= 1'b1;
                     out_data  <= head_a | head_b;
                     out_err   <= (head_a == '0) && (head_b == '0);
                     state     <= S_OUT;
                  end else begin
                     core_rst_q <= 1'b1;
                     state      <= S_CLR;
                  end
               end
            end
            S_CLR: begin
               start   <= 1'b1;
               data_in <= wa;
               state   <= S_LDA;
            end
            S_LDA: begin
               data_in <= wb;
               state   <= S_LDB;
            end
            S_LDB: begin
               cnt   <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (done) begin
                  out_valid <= 1'b1;
                  out_data  <= gcd_result;
                  out_err   <= 1'b0;
                  state     <= S_OUT;
               end else if (cnt_inc == TLIM) begin
                  cnt        <= cnt_inc;
                  out_valid  <= 1'b1;
                  out_data   <= '0;
                  out_err    <= 1'b1;
                  core_rst_q <= 1'b1;
                  state      <= S_OUT;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// tb_gcd_operand_sequencer: scoreboard bench with a behavioural GCD core model.
module tb_gcd_operand_sequencer;

   localparam int W  = 16;
   localparam int TO = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         core_rst;
   logic         start;
   logic [W-1:0] data_in;
   logic         done = 1'b0;
   logic [W-1:0] gcd_result = '0;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_err;
   logic         busy;

   always #5 clk = ~clk;

   gcd_operand_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .core_rst(core_rst), .start(start),
      .data_in(data_in), .done(done), .gcd_result(gcd_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_err(out_err), .busy(busy)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   typedef struct {
      logic [W-1:0] d;
      logic         e;
   } res_t;
   res_t sb[$];
   res_t r;

   function automatic logic [W-1:0] gcd_f(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] x, y, t;
      x = a;
      y = b;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // core model state and monitor bookkeeping
   int           cyc = 0, phase = 0, k = 0;
   logic         core_en = 1'b1, spur_idle = 1'b0, spur_lda = 1'b0;
   int           core_delay = 5;
   logic [W-1:0] ra = '0, rb = '0;
   int           clr_cyc = 0, start_cyc = 0, ldb_cyc = 0, ov_cyc = 0;
   int           n_core_rst = 0, n_start = 0, n_abort = 0, din_bad = 0;
   logic         prev_ov = 1'b0, hold_pending = 1'b0, hold_e = 1'b0;
   logic [W-1:0] hold_d = '0;

   // Core model plus output monitor, all sampled on the falling edge.
   always @(negedge clk) begin
      logic         done_n;
      logic [W-1:0] res_n;
      cyc++;
      done_n = 1'b0;
      res_n  = '0;
      if (!start && phase != 1 && data_in != '0) din_bad++;
      if (core_rst && out_valid) n_abort++;
      if (core_rst) begin
         if (!rst) begin
            n_core_rst++;
            clr_cyc = cyc;
         end
         phase = 0;
      end else if (start) begin
         n_start++;
         start_cyc = cyc;
         ra = data_in;
         phase = 1;
         if (spur_lda) begin
            done_n = 1'b1;
            res_n  = 16'd77;
         end
      end else if (phase == 1) begin
         rb = data_in;
         ldb_cyc = cyc;
         phase = 2;
         k = 0;
      end else if (phase == 2) begin
         k++;
         if (core_en && k == core_delay) begin
            done_n = 1'b1;
            res_n  = gcd_f(ra, rb);
            phase  = 0;
         end
      end
      if (spur_idle) begin
         done_n = 1'b1;
         res_n  = 16'd99;
      end
      done       = done_n;
      gcd_result = res_n;

      if (out_valid && !prev_ov) ov_cyc = cyc;
      prev_ov = out_valid;
      if (hold_pending && !rst) begin
         check("hold_valid", out_valid, 1);
         check("hold_data", out_data, hold_d);
         check("hold_err", out_err, hold_e);
      end
      hold_pending = out_valid && !out_ready;
      hold_d = out_data;
      hold_e = out_err;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) check("unexpected_result", 1, 0);
         else begin
            r = sb.pop_front();
            check("out_data", out_data, r.d);
            check("out_err", out_err, r.e);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] d, input logic e, input logic expect_res);
      int t;
      res_t x;
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      if (expect_res) begin
         x.d = d;
         x.e = e;
         sb.push_back(x);
      end
      t = 0;
      while (!in_ready && t < 100) begin
         tick(1);
         t++;
      end
      if (t == 100) check("push_timeout", 0, 1);
      tick(1);
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while ((busy || sb.size() != 0) && t < 300) begin
         tick(1);
         t++;
      end
      check("drain", (t < 300), 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, in_ready, 1);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_data"}, out_data, 0);
      check({tag, "_out_err"}, out_err, 0);
      check({tag, "_start"}, start, 0);
      check({tag, "_data_in"}, data_in, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_core_rst"}, core_rst, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int s_rst, s_start, s_abort, t;
      rst = 1'b1;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      out_ready = 1'b1;
      tick(2);
      check_reset_outputs("por");
      rst = 1'b0;
      tick(1);
      check("core_rst_released", core_rst, 0);

      // basic core job: gcd(12,18) = 6, done after 5 wait cycles
      core_delay = 5;
      push(12, 18, 6, 0, 1);
      wait_drain();
      check("lda_data", ra, 12);
      check("ldb_data", rb, 18);
      check("clr_to_lda", start_cyc - clr_cyc, 1);
      check("lda_to_ldb", ldb_cyc - start_cyc, 1);
      check("core_latency", ov_cyc - ldb_cyc, 6);

      // zero bypass: no core activity at all
      s_rst = n_core_rst;
      s_start = n_start;
      push(0, 9, 9, 0, 1);
      push(0, 0, 0, 1, 1);
      wait_drain();
      check("bypass_core_rst", n_core_rst - s_rst, 0);
      check("bypass_start", n_start - s_start, 0);

      // backpressure: three pairs with the consumer stalled
      out_ready = 1'b0;
      push(0, 5, 5, 0, 1);
      push(7, 0, 7, 0, 1);
      push(21, 14, 7, 0, 1);
      tick(1);
      check("full_in_ready", in_ready, 0);
      check("full_out_valid", out_valid, 1);
      check("full_busy", busy, 1);
      tick(3);
      out_ready = 1'b1;
      wait_drain();

      // timeout abort
      core_en = 1'b0;
      s_rst = n_core_rst;
      s_abort = n_abort;
      push(20, 30, 0, 1, 1);
      wait_drain();
      check("timeout_latency", ov_cyc - ldb_cyc, TO + 1);
      check("timeout_abort_pulse", n_abort - s_abort, 1);
      check("timeout_core_rst_cycles", n_core_rst - s_rst, 2);
      core_en = 1'b1;

      // done outside WAIT is ignored
      spur_idle = 1'b1;
      tick(3);
      check("spur_idle_busy", busy, 0);
      check("spur_idle_valid", out_valid, 0);
      spur_idle = 1'b0;
      spur_lda = 1'b1;
      core_delay = 3;
      push(8, 12, 4, 0, 1);
      wait_drain();
      spur_lda = 1'b0;
      check("spur_lda_latency", ov_cyc - ldb_cyc, 4);
      core_delay = 5;

      // reset mid-WAIT with one pair still queued
      core_en = 1'b0;
      push(9, 6, 0, 0, 0);
      push(4, 2, 0, 0, 0);
      t = 0;
      while (phase != 2 && t < 50) begin
         tick(1);
         t++;
      end
      check("reach_wait", (t < 50), 1);
      tick(2);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      tick(2);
      rst = 1'b0;
      tick(20);
      check("post_rst_in_ready", in_ready, 1);
      check("post_rst_busy", busy, 0);
      check("post_rst_valid", out_valid, 0);
      core_en = 1'b1;

      check("data_in_outside_load", din_bad, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
